level_sequencer: RTL
====================

# level_sequencer

Top-level game-flow controller that sequences play across levels: title screen, per-level play, level-clear and death interstitials, game over and victory. It owns the active level's reset, selects which level drives VGA, and consumes the selected level's `win` and `lose` flags. It also tracks remaining lives. It sits between the board I/O and the level instances, one level above the per-level modules.

## Interface
Parameters:
- `NUM_LEVELS`, default 2: number of level instances; `level_index` ranges 0..NUM_LEVELS-1.
- `LIVES`, default 3: lives granted on game start.
- `HOLD_CYCLES`, default 50_000_000: interstitial duration in vga_clock cycles (2 s at 25 MHz).
- `GUARD_CYCLES`, default 4: PLAY cycles during which win/lose are ignored after level reset release.
- `LEVEL_W`, default $clog2(NUM_LEVELS) (min 1); `LIVES_W`, default $clog2(LIVES+1).

Ports:
- `vga_clock`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-low.
- `start_button`, in, 1: raw active-high button, asynchronous to vga_clock.
- `level_win`, in, 1: selected level's `win`.
- `level_lose`, in, 1: selected level's `lose`.
- `level_reset_n`, out, 1: active-low reset to the selected level.
- `level_index`, out, LEVEL_W: selected level (VGA/flag mux select).
- `screen_mode`, out, 3: screen_mode_t (TITLE, PLAY, CLEAR, DIED, GAME_OVER, VICTORY).
- `lives`, out, LIVES_W: remaining lives.
- `leds`, out, 10: [9:8] level_index zero-extended; [7:0] thermometer of lives (lives ones from bit 0).

## Operation
- State register holds one of the six modes. `screen_mode` equals state. `level_reset_n` = (state == PLAY).
- Start event: `start_button` passes a 2-flop synchroniser, then a rising-edge detect gives a 1-cycle `start_pulse`.
- TITLE: on start_pulse, set level_index=0 and lives=LIVES, clear guard, go to PLAY.
- PLAY: guard counter increments to GUARD_CYCLES and saturates. Flags are sampled only when guard == GUARD_CYCLES.
  - win with level_index < NUM_LEVELS-1 → CLEAR.
  - win on the last level → VICTORY.
  - Otherwise, lose with lives > 1 → DIED and lives-1.
  - Otherwise, lose with lives == 1 → GAME_OVER and lives=0.
  - win and lose in the same cycle: win has priority.
- CLEAR: hold counter loads HOLD_CYCLES-1 on entry and counts down. At 0, or on start_pulse, increment level_index, clear guard, go to PLAY.
- DIED: same hold behaviour; level_index is unchanged and the level restarts via the reset.
- GAME_OVER / VICTORY: wait for start_pulse, then go to TITLE. lives and level_index hold until then.
- start_pulse during PLAY is ignored.
- Arithmetic is unsigned. lives never underflows. level_index never exceeds NUM_LEVELS-1.

## Timing
- On reset low (async): state=TITLE, level_reset_n=0, level_index=0, lives=LIVES, screen_mode=TITLE, leds reflect those values, counters=0, synchroniser=0.
- start_button rising edge to start_pulse: 3 cycles (2 sync + 1 edge register). State changes on the edge after start_pulse.
- All outputs are registered or decoded from registers only; no combinational input-to-output path.
- Win/lose sampled at edge N → new state and level_reset_n=0 visible after edge N. The level is held in reset from the next cycle onward.
- Interstitial duration: exactly HOLD_CYCLES cycles in CLEAR/DIED, then 1 cycle to PLAY.
- Minimum reset pulse to a level is HOLD_CYCLES cycles, or 1 cycle if skipped by start.
- After PLAY entry, flags are ignored for GUARD_CYCLES cycles. This masks stale `lose` (e.g. a timer reading 0) while the level comes out of reset.
- Reset mid-interstitial or mid-PLAY: immediate return to the reset state. Counters are discarded.

## Structure
- Shared package `game_pkg`: screen_mode_t enum (3 bits: TITLE=0, PLAY=1, CLEAR=2, DIED=3, GAME_OVER=4, VICTORY=5), and the default HOLD_CYCLES and GUARD_CYCLES constants.
- One sub-module, `button_edge_detector`: 2-flop synchroniser plus rising-edge pulse, with async active-low reset. It is reused later for the other buttons.
- The FSM, counters and led encoding live in `level_sequencer`.

## Test plan
Bench settings: HOLD_CYCLES=8, GUARD_CYCLES=4, NUM_LEVELS=2, LIVES=3.
- Reset then start press → PLAY exactly 3 cycles + 1 edge after the rising edge. level_index=0, lives=3, level_reset_n=1, leds=10'b00_00000111.
- In PLAY, win asserted at guard cycle 2 → ignored. Win held to cycle 4 → CLEAR, level_reset_n=0. After 8 cycles → PLAY with level_index=1, leds[9:8]=01.
- Win on level 1 → VICTORY. Start → TITLE. Start again → level_index=0, lives=3.
- Three lose events → DIED (lives 2), DIED (lives 1), then GAME_OVER (lives 0). level_index unchanged throughout.
- win and lose in the same sampled cycle on level 0 → CLEAR, lives unchanged. Start press during CLEAR at hold cycle 3 → PLAY on the following edge.
- reset low asserted mid-DIED → TITLE, lives=3, level_reset_n=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Brief    : Shared game-flow types and default timing constants used by the
//             level sequencer and the per-level blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Screen currently shown; doubles as the game-flow state encoding.
    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        PLAY      = 3'd1,
        CLEAR     = 3'd2,
        DIED      = 3'd3,
        GAME_OVER = 3'd4,
        VICTORY   = 3'd5
    } screen_mode_t;

    // Interstitial length: 2 s at the 25 MHz pixel clock.
    localparam int DEFAULT_HOLD_CYCLES  = 50_000_000;

    // PLAY cycles during which win/lose are ignored after the level leaves reset.
    localparam int DEFAULT_GUARD_CYCLES = 4;

endpackage : game_pkg
`default_nettype wire

// File: rtl/button_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : button_edge_detector
//  Brief    : Brings a raw asynchronous push-button into the vga_clock domain
//             through a two-flop synchroniser and emits a registered one-cycle
//             pulse on each rising edge. Latency from the button edge to the
//             pulse is three clock edges.
//  Revision : 1.0 - initial release
// ============================================================================
module button_edge_detector (
    input  logic vga_clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    logic r_sync_1;
    logic r_sync_2;
    logic r_prev;

    // Synchronise the button, remember its last level and register the rising edge.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_sync_1 <= 1'b0;
            r_sync_2 <= 1'b0;
            r_prev   <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            r_sync_1 <= button;
            r_sync_2 <= r_sync_1;
            r_prev   <= r_sync_2;
            pulse    <= r_sync_2 & ~r_prev;
        end
    end

endmodule : button_edge_detector
`default_nettype wire

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : level_sequencer
//  Brief    : Game-flow controller. Walks title -> play -> clear/died
//             interstitials -> game over / victory, drives the selected
//             level's active-low reset and mux select, tracks remaining lives
//             and encodes level/lives onto the board LEDs.
//  Revision : 1.0 - initial release
// ============================================================================
module level_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 2,
    parameter int LIVES        = 3,
    parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES,
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    parameter int LEVEL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int LIVES_W      = (LIVES > 0) ? $clog2(LIVES + 1) : 1
) (
    input  logic               vga_clock,
    input  logic               reset,
    input  logic               start_button,
    input  logic               level_win,
    input  logic               level_lose,
    output logic               level_reset_n,
    output logic [LEVEL_W-1:0] level_index,
    output screen_mode_t       screen_mode,
    output logic [LIVES_W-1:0] lives,
    output logic [9:0]         leds
);

    localparam int GUARD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] START_LIVES = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE    = LIVES_W'(1);
    localparam logic [GUARD_W-1:0] GUARD_MAX   = GUARD_W'(GUARD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);

    screen_mode_t       r_state;
    logic [GUARD_W-1:0] r_guard_count;
    logic [HOLD_W-1:0]  r_hold_count;
    logic               w_start_pulse;
    logic               w_flags_live;
    logic               w_hold_done;
    logic               w_more_levels;
    logic [7:0]         w_lives_therm;
    logic [1:0]         w_led_level;

    button_edge_detector u_start_edge (
        .vga_clock (vga_clock),
        .reset     (reset),
        .button    (start_button),
        .pulse     (w_start_pulse)
    );

    // Flags only count once the freshly released level has settled.
    assign w_flags_live  = (r_guard_count == GUARD_MAX);
    // Interstitial ends when the countdown expires or the player skips it.
    assign w_hold_done   = (r_hold_count == '0) || w_start_pulse;
    assign w_more_levels = (level_index < LAST_LEVEL);

    // Game-flow state machine with its guard/hold counters, level select and lives.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_state       <= TITLE;
            r_guard_count <= '0;
            r_hold_count  <= '0;
            level_index   <= '0;
            lives         <= START_LIVES;
        end else begin
            case (r_state)
                TITLE: begin
                    if (w_start_pulse) begin
                        level_index   <= '0;
                        lives         <= START_LIVES;
                        r_guard_count <= '0;
                        r_state       <= PLAY;
                    end
                end

                PLAY: begin
                    if (!w_flags_live) begin
                        r_guard_count <= r_guard_count + GUARD_W'(1);
                    end else if (level_win) begin
                        // Win beats a simultaneous lose.
                        r_hold_count <= HOLD_LOAD;
                        r_state      <= w_more_levels ? CLEAR : VICTORY;
                    end else if (level_lose) begin
                        r_hold_count <= HOLD_LOAD;
                        if (lives > ONE_LIFE) begin
                            lives   <= lives - ONE_LIFE;
                            r_state <= DIED;
                        end else begin
                            lives   <= '0;
                            r_state <= GAME_OVER;
                        end
                    end
                end

                CLEAR, DIED: begin
                    if (w_hold_done) begin
                        // A death replays the same level; the reset pulse restarts it.
                        if ((r_state == CLEAR) && w_more_levels) begin
                            level_index <= level_index + LEVEL_W'(1);
                        end
                        r_guard_count <= '0;
                        r_state       <= PLAY;
                    end else begin
                        r_hold_count <= r_hold_count - HOLD_W'(1);
                    end
                end

                GAME_OVER, VICTORY: begin
                    // Final lives/level stay on the LEDs until the player restarts.
                    if (w_start_pulse) begin
                        r_state <= TITLE;
                    end
                end

                default: begin
                    r_state <= TITLE;
                end
            endcase
        end
    end

    assign screen_mode   = r_state;
    assign level_reset_n = (r_state == PLAY);

    // Lives thermometer: bit i lit while more than i lives remain.
    for (genvar i = 0; i < 8; i++) begin : g_therm
        if (i < (1 << LIVES_W)) begin : g_cmp
            assign w_lives_therm[i] = (lives > LIVES_W'(i));
        end else begin : g_zero
            assign w_lives_therm[i] = 1'b0;
        end
    end

    if (LEVEL_W >= 2) begin : g_led_level_wide
        assign w_led_level = level_index[1:0];
    end else begin : g_led_level_narrow
        assign w_led_level = {1'b0, level_index};
    end

    assign leds = {w_led_level, w_lives_therm};

endmodule : level_sequencer
`default_nettype wire
